// File: rtl/hilo_muldiv_controller_pkg.sv
// Shared pipeline definitions for the HI/LO multiply/divide unit:
// opcode encodings, controller state encoding and opcode decode helpers.
package hilo_muldiv_controller_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_FIXUP = ST_FIXUP
    } state_t;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_controller_if.sv
// EX-stage / hazard-unit side of the HI/LO multiply/divide controller.
interface hilo_muldiv_controller_if #(
    parameter int DATA_W = 32
);
    logic              Start;
    logic [2:0]        Op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              HiLoRead;
    logic              Flush;
    logic              StallReq;
    logic              Busy;
    logic              Done;
    logic              DivByZero;
    logic [DATA_W-1:0] Hi;
    logic [DATA_W-1:0] Lo;

    modport master (
        output Start, Op, A, B, HiLoRead, Flush,
        input  StallReq, Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, HiLoRead, Flush,
        output StallReq, Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/hilo_muldiv_controller_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one bit per step, with its own iteration counter.
module muldiv_iter_core
    import hilo_muldiv_controller_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITERS  = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                i_load,
    input  logic                i_div,
    input  logic                i_step,
    input  logic                i_clr,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0]   o_rem,
    output logic                o_last
);
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_b;
    logic                r_div;

    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_mul_next;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W+1:0]   w_trial;
    logic [DATA_W-1:0]   w_q_next;
    logic [DATA_W-1:0]   w_rem_next;

    // Multiply: acc low half holds the remaining multiplier bits; the carry
    // out of the high-half add is kept by shifting the DATA_W+1 sum back in.
    assign w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_sum, r_acc[DATA_W-1:1]};

    // Divide: acc low half shifts dividend bits out and quotient bits in.
    assign w_shift    = {r_rem, r_acc[DATA_W-1]};
    assign w_trial    = {1'b0, w_shift} - {2'b00, r_b};
    assign w_q_next   = {r_acc[DATA_W-2:0], ~w_trial[DATA_W+1]};
    assign w_rem_next = w_trial[DATA_W+1] ? w_shift[DATA_W-1:0] : DATA_W'(w_trial);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(ITERS);
        end else if (i_step && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (i_load) begin
            r_acc <= {{DATA_W{1'b0}}, i_a};
            r_rem <= '0;
            r_b   <= i_b;
            r_div <= i_div;
        end else if (i_step) begin
            if (r_div) begin
                r_acc <= {{DATA_W{1'b0}}, w_q_next};
                r_rem <= w_rem_next;
            end else begin
                r_acc <= w_mul_next;
            end
        end
    end

    assign o_acc  = r_acc;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/hilo_muldiv_controller.sv
// HI/LO multiply/divide controller: IDLE/RUN/FIXUP sequencing, sign
// handling, MTHI/MTLO, hazard stall request and the architectural HI/LO.
module hilo_muldiv_controller
    import hilo_muldiv_controller_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITERS  = 32
) (
    input logic                     Clk,
    input logic                     Rst,
    hilo_muldiv_controller_if.slave bus
);
    state_t              r_state;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_is_div;
    logic                r_done;
    logic                r_dbz;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_idle;
    logic                w_take;
    logic                w_is_div;
    logic                w_signed;
    logic                w_div0;
    logic                w_launch;
    logic                w_step;
    logic                w_clr;
    logic                w_last;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [2*DATA_W-1:0] w_acc;
    logic [2*DATA_W-1:0] w_prod;

    function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] u;
        u = x;
        return x[DATA_W-1] ? -u : u;
    endfunction

    function automatic logic [DATA_W-1:0] f_neg_w(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] f_neg_2w(input logic neg, input logic [2*DATA_W-1:0] x);
        return neg ? -x : x;
    endfunction

    // Flush in IDLE discards a same-cycle Start of any kind.
    assign w_idle   = (r_state == S_IDLE);
    assign w_take   = w_idle && bus.Start && !bus.Flush;
    assign w_is_div = op_is_div(bus.Op);
    assign w_signed = op_is_signed(bus.Op);
    assign w_div0   = w_is_div && (bus.B == '0);
    assign w_launch = w_take && op_is_muldiv(bus.Op) && !w_div0;
    assign w_a_mag  = w_signed ? f_abs(bus.A) : bus.A;
    assign w_b_mag  = w_signed ? f_abs(bus.B) : bus.B;
    assign w_step   = (r_state == S_RUN) && !bus.Flush;
    assign w_clr    = !w_idle && bus.Flush;

    muldiv_iter_core #(
        .DATA_W (DATA_W),
        .ITERS  (ITERS)
    ) u_core (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_load (w_launch),
        .i_div  (w_is_div),
        .i_step (w_step),
        .i_clr  (w_clr),
        .i_a    (w_a_mag),
        .i_b    (w_b_mag),
        .o_acc  (w_acc),
        .o_rem  (w_rem),
        .o_last (w_last)
    );

    assign w_prod    = f_neg_2w(r_neg_res, w_acc);
    assign w_quo     = f_neg_w(r_neg_res, w_acc[DATA_W-1:0]);
    assign w_rem_fix = f_neg_w(r_neg_rem, w_rem);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_is_div  <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        if (bus.Op == OP_MTHI) begin
                            r_hi <= bus.A;
                        end else if (bus.Op == OP_MTLO) begin
                            r_lo <= bus.A;
                        end else if (w_div0) begin
                            r_dbz <= 1'b1;
                        end else if (w_launch) begin
                            r_state   <= S_RUN;
                            r_is_div  <= w_is_div;
                            r_neg_res <= w_signed && (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
                            r_neg_rem <= w_signed && w_is_div && bus.A[DATA_W-1];
                        end
                    end
                end
                S_RUN: begin
                    if (bus.Flush) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_FIXUP;
                        r_done  <= 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_state <= S_IDLE;
                    if (!bus.Flush) begin
                        if (r_is_div) begin
                            r_lo <= w_quo;
                            r_hi <= w_rem_fix;
                        end else begin
                            r_hi <= w_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod[DATA_W-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A flush arriving during FIXUP retracts that cycle's Done pulse.
    assign bus.Busy      = !w_idle;
    assign bus.StallReq  = !w_idle && (bus.HiLoRead || bus.Start);
    assign bus.Done      = r_done && !bus.Flush;
    assign bus.DivByZero = r_dbz;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Directed bench for hilo_muldiv_controller with hand-computed expectations.
module tb_hilo_muldiv_controller;
    import hilo_muldiv_controller_pkg::*;

    logic Clk = 1'b0;
    logic Rst;
    int   errors = 0;
    int   checks = 0;
    int   cnt;

    hilo_muldiv_controller_if #(.DATA_W(32)) bus();

    hilo_muldiv_controller #(
        .DATA_W (32),
        .ITERS  (32)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Presents the op for one edge (E0); returns in cycle E1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        tick(1);
        bus.Start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Rst          = 1'b1;
        bus.Start    = 1'b0;
        bus.Op       = 3'b000;
        bus.A        = '0;
        bus.B        = '0;
        bus.HiLoRead = 1'b0;
        bus.Flush    = 1'b0;
        tick(2);
        chk("rst_hi", bus.Hi, 0);
        chk("rst_lo", bus.Lo, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_dbz", bus.DivByZero, 0);
        chk("rst_stall", bus.StallReq, 0);
        Rst = 1'b0;
        tick(1);

        // MULT -2 x 3 with cycle-accurate Done
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy_e1", bus.Busy, 1);
        tick(31);
        chk("mult_done_e32", bus.Done, 0);
        tick(1);
        chk("mult_done_e33", bus.Done, 1);
        chk("mult_busy_e33", bus.Busy, 1);
        tick(1);
        chk("mult_done_e34", bus.Done, 0);
        chk("mult_busy_e34", bus.Busy, 0);
        chk("mult_hi", bus.Hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.Lo, 32'hFFFF_FFFA);
        bus.HiLoRead = 1'b1;
        #1;
        chk("mult_nostall_e34", bus.StallReq, 0);
        bus.HiLoRead = 1'b0;

        // Signed and unsigned divide
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        tick(33);
        chk("div_lo", bus.Lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.Hi, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'd7, 32'd2);
        tick(33);
        chk("divu_lo", bus.Lo, 32'd3);
        chk("divu_hi", bus.Hi, 32'd1);

        // Divide by zero
        issue(OP_DIVU, 32'd9, 32'd0);
        chk("dbz_pulse", bus.DivByZero, 1);
        chk("dbz_busy", bus.Busy, 0);
        tick(1);
        chk("dbz_pulse_end", bus.DivByZero, 0);
        chk("dbz_busy2", bus.Busy, 0);
        chk("dbz_hi", bus.Hi, 32'd1);
        chk("dbz_lo", bus.Lo, 32'd3);

        // MULTU max x max with HiLoRead held
        bus.HiLoRead = 1'b1;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cnt = 0;
        for (int c = 1; c <= 33; c++) begin
            if (bus.StallReq) cnt++;
            if (c < 33) tick(1);
        end
        chk("multu_stall_cycles", cnt, 33);
        tick(1);
        chk("multu_stall_e34", bus.StallReq, 0);
        chk("multu_hi", bus.Hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.Lo, 32'h0000_0001);
        bus.HiLoRead = 1'b0;

        // Most-negative / -1 divide
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        tick(33);
        chk("divmin_lo", bus.Lo, 32'h8000_0000);
        chk("divmin_hi", bus.Hi, 32'h0);

        // Flush at E10 of a MULT, then MTLO
        issue(OP_MULT, 32'd5, 32'd7);
        tick(9);
        bus.Flush = 1'b1;
        tick(1);
        bus.Flush = 1'b0;
        chk("flush_busy_e11", bus.Busy, 0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.Done) cnt++;
            tick(1);
        end
        chk("flush_no_done", cnt, 0);
        chk("flush_hi", bus.Hi, 32'h0);
        chk("flush_lo", bus.Lo, 32'h8000_0000);
        issue(OP_MTLO, 32'h0000_1234, 32'd0);
        chk("mtlo_lo", bus.Lo, 32'h0000_1234);
        chk("mtlo_hi", bus.Hi, 32'h0);
        chk("mtlo_busy", bus.Busy, 0);
        issue(OP_MTHI, 32'h0000_ABCD, 32'd0);
        chk("mthi_hi", bus.Hi, 32'h0000_ABCD);

        // Flush beats Start in the same IDLE cycle
        bus.Flush = 1'b1;
        issue(OP_MTHI, 32'h5555_5555, 32'd0);
        chk("flushstart_mthi", bus.Hi, 32'h0000_ABCD);
        issue(OP_MULT, 32'd2, 32'd2);
        bus.Flush = 1'b0;
        chk("flushstart_mult", bus.Busy, 0);

        // Asynchronous reset mid-RUN
        issue(OP_MULT, 32'd3, 32'd3);
        bus.HiLoRead = 1'b1;
        tick(10);
        chk("prerst_stall", bus.StallReq, 1);
        #2 Rst = 1'b1;
        #1;
        chk("arst_hi", bus.Hi, 0);
        chk("arst_lo", bus.Lo, 0);
        chk("arst_busy", bus.Busy, 0);
        chk("arst_stall", bus.StallReq, 0);
        chk("arst_done", bus.Done, 0);
        #1 Rst = 1'b0;
        bus.HiLoRead = 1'b0;
        tick(1);
        issue(OP_MULT, 32'd5, 32'd6);
        tick(33);
        chk("postrst_lo", bus.Lo, 32'd30);
        chk("postrst_hi", bus.Hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
